// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_pkg
// Purpose  : Shared core types for the EX-stage multiply/divide path and the
//            forwarding unit: M-extension opcodes, forwarding selects, FSM
//            state encodings and small opcode-decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ex_muldiv_unit_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  // Operand source selects driven by the forwarding unit (11 is illegal)
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // rs1 is interpreted as signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic op_a_signed(input logic [2:0] f3);
    logic r;
    case (f3)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  // rs2 is interpreted as signed for MUL/MULH/DIV/REM
  function automatic logic op_b_signed(input logic [2:0] f3);
    logic r;
    case (f3)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : ex_fwd_mux
// Purpose  : Three-source operand mux (register file / MEM / WB) steered by a
//            forwarding-unit select. Shared by the ALU and mul/div paths.
// Revision : 1.0 - initial release
// ============================================================================
module ex_fwd_mux
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel_i,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Select forwarded data; the illegal code falls back to register data
  always_comb begin
    data_o = reg_data_i;
    case (sel_i)
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : EX-stage RV32M multiply/divide unit. Selects forwarded operands,
//            latches them at issue, iterates a 32-cycle shift-add multiply or
//            restoring divide while stalling the front end, then hands the
//            result to EX/MEM under a valid/ready handshake.
// Config   : MULDIV_FAST_MUL_EN - when defined, multiplies use a single
//            registered 33x33 signed multiplier and complete in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_is_muldiv,
  input  logic [2:0]            ex_funct3,
  input  logic [4:0]            ex_rd_addr,
  input  logic [DATA_WIDTH-1:0] ex_rs1_data,
  input  logic [DATA_WIDTH-1:0] ex_rs2_data,
  input  logic [1:0]            forward_a,
  input  logic [1:0]            forward_b,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  input  logic                  flush,
  input  logic                  mem_ready,
  output logic                  ex_stall,
  output logic                  md_valid,
  output logic [DATA_WIDTH-1:0] md_result,
  output logic [4:0]            md_rd_addr,
  output logic                  md_busy
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = MD_IDLE;
  localparam logic [1:0] S_BUSY = MD_BUSY;
  localparam logic [1:0] S_DONE = MD_DONE;

  localparam logic [W-1:0] C_ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] C_INT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [5:0]   C_LAST_CNT = 6'(W-1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]     state_q,  state_d;
  logic [5:0]     cnt_q,    cnt_d;
  logic [2*W-1:0] acc_q,    acc_d;     // mul: {hi, multiplier}; div: {rem, quotient}
  logic [W-1:0]   mcand_q,  mcand_d;   // multiplicand or divisor magnitude
  logic [2:0]     op_q,     op_d;
  logic           neg_q,    neg_d;     // negate final result
  logic [W-1:0]   result_q, result_d;
  logic [4:0]     rd_q,     rd_d;

  // --------------------------------------------------------------------------
  // Operand selection
  // --------------------------------------------------------------------------
  logic [W-1:0] w_op_a, w_op_b;

  ex_fwd_mux #(.DATA_WIDTH(W)) u_fwd_a (
    .sel_i      (forward_a),
    .reg_data_i (ex_rs1_data),
    .mem_data_i (mem_fwd_data),
    .wb_data_i  (wb_fwd_data),
    .data_o     (w_op_a)
  );

  ex_fwd_mux #(.DATA_WIDTH(W)) u_fwd_b (
    .sel_i      (forward_b),
    .reg_data_i (ex_rs2_data),
    .mem_data_i (mem_fwd_data),
    .wb_data_i  (wb_fwd_data),
    .data_o     (w_op_b)
  );

  // --------------------------------------------------------------------------
  // Issue-time decode: magnitudes, result sign and special cases
  // --------------------------------------------------------------------------
  logic         w_start;
  logic         w_is_div;
  logic         w_a_neg, w_b_neg;
  logic [W-1:0] w_a_mag, w_b_mag;
  logic         w_neg_issue;
  logic         w_div_zero, w_div_ovf, w_special;
  logic [W-1:0] w_special_res;

  assign w_start  = ex_valid & ex_is_muldiv & (state_q == S_IDLE) & ~flush;
  assign w_is_div = ex_funct3[2];

  assign w_a_neg  = op_a_signed(ex_funct3) & w_op_a[W-1];
  assign w_b_neg  = op_b_signed(ex_funct3) & w_op_b[W-1];
  assign w_a_mag  = w_a_neg ? (~w_op_a + 1'b1) : w_op_a;
  assign w_b_mag  = w_b_neg ? (~w_op_b + 1'b1) : w_op_b;

  // Remainders take the dividend's sign; quotients and products the XOR
  assign w_neg_issue = (w_is_div & ex_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // Signed DIV/REM have funct3[0]==0; REM/REMU have funct3[1]==1
  assign w_div_zero = w_is_div & (w_op_b == '0);
  assign w_div_ovf  = w_is_div & ~ex_funct3[0] & (w_op_a == C_INT_MIN) &
                      (w_op_b == C_ALL_ONES);
  assign w_special  = w_div_zero | w_div_ovf;

  assign w_special_res = w_div_zero ? (ex_funct3[1] ? w_op_a : C_ALL_ONES)
                                    : (ex_funct3[1] ? '0     : C_INT_MIN);

  // --------------------------------------------------------------------------
  // Optional single-cycle multiplier
  // --------------------------------------------------------------------------
  logic         w_fast_hit;
  logic [W-1:0] w_fast_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]     w_fast_a, w_fast_b;
  logic signed [2*W+1:0] w_fast_prod;

  assign w_fast_a    = {op_a_signed(ex_funct3) & w_op_a[W-1], w_op_a};
  assign w_fast_b    = {op_b_signed(ex_funct3) & w_op_b[W-1], w_op_b};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_hit  = ~ex_funct3[2];
  assign w_fast_res  = (ex_funct3 == OP_MUL) ? w_fast_prod[W-1:0]
                                             : w_fast_prod[2*W-1:W];
`else
  assign w_fast_hit  = 1'b0;
  assign w_fast_res  = '0;
`endif

  // --------------------------------------------------------------------------
  // Iteration step: shift-add multiply or restoring divide, one bit per cycle
  // --------------------------------------------------------------------------
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_rem_sh;
  logic           w_rem_ge;
  logic [W-1:0]   w_rem_diff;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_acc_next;

  assign w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[W-1:1]};

  // Partial remainder is always below the divisor, so the difference fits in W bits
  assign w_rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, mcand_q});
  assign w_rem_diff = w_rem_sh[W-1:0] - mcand_q;
  assign w_div_next = {(w_rem_ge ? w_rem_diff : w_rem_sh[W-1:0]),
                       acc_q[W-2:0], w_rem_ge};

  assign w_acc_next = op_q[2] ? w_div_next : w_mul_next;

  // --------------------------------------------------------------------------
  // Completion: sign fix-up and result selection from the final step
  // --------------------------------------------------------------------------
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo_fix, w_rem_fix;
  logic [W-1:0]   w_final;

  assign w_prod_fix = neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_quo_fix  = neg_q ? (~w_acc_next[W-1:0] + 1'b1) : w_acc_next[W-1:0];
  assign w_rem_fix  = neg_q ? (~w_acc_next[2*W-1:W] + 1'b1) : w_acc_next[2*W-1:W];

  // Pick the low product, high product, quotient or remainder
  always_comb begin
    w_final = '0;
    case (op_q)
      OP_MUL:                       w_final = w_prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              w_final = w_quo_fix;
      OP_REM, OP_REMU:              w_final = w_rem_fix;
      default:                      w_final = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state: issue, iterate, hold result until accepted
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            op_d    = ex_funct3;
            rd_d    = ex_rd_addr;
            neg_d   = w_neg_issue;
            cnt_d   = '0;
            mcand_d = w_is_div ? w_b_mag : w_a_mag;
            acc_d   = {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            if (w_special) begin
              result_d = w_special_res;
              state_d  = S_DONE;
            end else if (w_fast_hit) begin
              result_d = w_fast_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = w_acc_next;
          if (cnt_q == C_LAST_CNT) begin
            cnt_d    = '0;
            result_d = w_final;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          if (mem_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign md_valid   = (state_q == S_DONE);
  assign md_busy    = (state_q != S_IDLE);
  assign md_result  = result_q;
  assign md_rd_addr = rd_q;
  assign ex_stall   = ~flush & (w_start | (state_q == S_BUSY) |
                                ((state_q == S_DONE) & ~mem_ready));

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed, scoreboard-checked bench for ex_muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_is_muldiv;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        mem_ready;
  logic        ex_stall;
  logic        md_valid;
  logic [31:0] md_result;
  logic [4:0]  md_rd_addr;
  logic        md_busy;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_is_muldiv (ex_is_muldiv),
    .ex_funct3    (ex_funct3),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_data  (wb_fwd_data),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .ex_stall     (ex_stall),
    .md_valid     (md_valid),
    .md_result    (md_result),
    .md_rd_addr   (md_rd_addr),
    .md_busy      (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: on each rising md_valid pop the oldest expectation and compare
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (md_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, md_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("result", md_result, mon_e.res);
          chk("rd_addr", {27'b0, md_rd_addr}, {27'b0, mon_e.rd});
          chk("valid_cycle", cyc, mon_e.cyc);
        end
      end
      prev_v = md_valid;
    end
  end

  // Issue one op at the current negedge, wait for its result, optionally
  // hold mem_ready low for 'hold' DONE cycles, then let EX/MEM accept it.
  task automatic issue_op(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] memd, input logic [31:0] wbd,
                          input logic [4:0] rd, input logic [31:0] expv,
                          input int lat, input int hold);
    exp_t e;
    int   n;
    ex_valid     = 1'b1;
    ex_is_muldiv = 1'b1;
    ex_funct3    = f3;
    ex_rs1_data  = rs1;
    ex_rs2_data  = rs2;
    forward_a    = fa;
    forward_b    = fb;
    mem_fwd_data = memd;
    wb_fwd_data  = wbd;
    ex_rd_addr   = rd;
    mem_ready    = (hold == 0);
    e.res = expv;
    e.rd  = rd;
    e.cyc = cyc + lat;
    sb.push_back(e);
    #1 chk("stall_at_issue", {31'b0, ex_stall}, 32'd1);
    @(negedge clk);
    // Operand sources change after issue; the result must not follow them
    ex_valid     = 1'b0;
    ex_rs1_data  = 32'h13579BDF;
    ex_rs2_data  = 32'h2468ACE0;
    mem_fwd_data = 32'hDEADBEEF;
    wb_fwd_data  = 32'h0BADF00D;
    ex_rd_addr   = 5'd31;
    n = 0;
    while (!md_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!md_valid) begin
      chk("valid_timeout", {31'b0, md_valid}, 32'd1);
      mem_ready = 1'b1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'b0, md_valid}, 32'd1);
      chk("hold_result", md_result, expv);
      chk("hold_stall", {31'b0, ex_stall}, 32'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 chk("accept_stall", {31'b0, ex_stall}, 32'd0);
    @(negedge clk);
    chk("idle_after_accept", {31'b0, md_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    ex_valid     = 1'b0;
    ex_is_muldiv = 1'b0;
    ex_funct3    = 3'b000;
    ex_rd_addr   = 5'd0;
    ex_rs1_data  = 32'd0;
    ex_rs2_data  = 32'd0;
    forward_a    = 2'b00;
    forward_b    = 2'b00;
    mem_fwd_data = 32'd0;
    wb_fwd_data  = 32'd0;
    flush        = 1'b0;
    mem_ready    = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid",  {31'b0, md_valid}, 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_rd",     {27'b0, md_rd_addr}, 32'd0);
    chk("rst_busy",   {31'b0, md_busy}, 32'd0);
    chk("rst_stall",  {31'b0, ex_stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'b0, ex_stall}, 32'd0);

    //        f3      rs1           rs2           fa     fb     mem           wb            rd     expected      lat      hold
    issue_op(3'b000, 32'd7,        32'd6,        2'b00, 2'b00, 32'd0,        32'd0,        5'd5,  32'd42,       MUL_LAT, 0);
    issue_op(3'b100, 32'd2,        32'd2,        2'b10, 2'b00, 32'hFFFFFFF9, 32'd0,        5'd6,  32'hFFFFFFFD, DIV_LAT, 0);
    issue_op(3'b110, 32'd2,        32'd2,        2'b10, 2'b00, 32'hFFFFFFF9, 32'd0,        5'd7,  32'hFFFFFFFF, DIV_LAT, 0);
    issue_op(3'b001, 32'h80000000, 32'd1,        2'b00, 2'b01, 32'd0,        32'h80000000, 5'd8,  32'h40000000, MUL_LAT, 0);
    issue_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0,        32'd0,        5'd9,  32'hFFFFFFFE, MUL_LAT, 0);
    issue_op(3'b010, 32'hFFFFFFFF, 32'd2,        2'b00, 2'b00, 32'd0,        32'd0,        5'd10, 32'hFFFFFFFF, MUL_LAT, 0);
    issue_op(3'b101, 32'd5,        32'd0,        2'b00, 2'b00, 32'd0,        32'd0,        5'd11, 32'hFFFFFFFF, 1,       0);
    issue_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0,        32'd0,        5'd12, 32'h80000000, 1,       0);
    issue_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0,        32'd0,        5'd13, 32'h00000000, 1,       0);
    issue_op(3'b110, 32'h00001234, 32'd0,        2'b00, 2'b00, 32'd0,        32'd0,        5'd14, 32'h00001234, 1,       0);
    issue_op(3'b100, 32'hFFFFFF9C, 32'd7,        2'b00, 2'b11, 32'd3,        32'd3,        5'd15, 32'hFFFFFFF2, DIV_LAT, 0);
    issue_op(3'b111, 32'd100,      32'd7,        2'b11, 2'b00, 32'd50,       32'd60,       5'd16, 32'd2,        DIV_LAT, 0);
    issue_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0,        32'd0,        5'd0,  32'd1,        MUL_LAT, 3);
    issue_op(3'b110, 32'hFFFFFF9C, 32'd7,        2'b00, 2'b00, 32'd0,        32'd0,        5'd17, 32'hFFFFFFFE, DIV_LAT, 2);

    // Flush while iterating a divide: back to IDLE, never presents a result
    begin
      int c0;
      ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct3 = 3'b101;
      ex_rs1_data = 32'd1000; ex_rs2_data = 32'd3;
      forward_a = 2'b00; forward_b = 2'b00; ex_rd_addr = 5'd20;
      c0 = cyc;
      @(negedge clk);
      ex_valid = 1'b0;
      while (cyc < c0 + 10) @(negedge clk);
      chk("busy_before_flush", {31'b0, md_busy}, 32'd1);
      flush = 1'b1;
      #1 chk("flush_stall", {31'b0, ex_stall}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {31'b0, md_busy}, 32'd0);
      chk("flush_stall_after", {31'b0, ex_stall}, 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_no_valid", {31'b0, md_valid}, 32'd0);
    end

    // Flush has priority over a simultaneous start
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct3 = 3'b000;
    flush = 1'b1;
    #1 chk("flush_vs_start_stall", {31'b0, ex_stall}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", {31'b0, md_busy}, 32'd0);

    // Asynchronous reset mid-operation clears everything at once
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct3 = 3'b100;
    ex_rs1_data = 32'd77; ex_rs2_data = 32'd5; ex_rd_addr = 5'd21;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_reset", {31'b0, md_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  {31'b0, md_valid}, 32'd0);
    chk("arst_result", md_result, 32'd0);
    chk("arst_rd",     {27'b0, md_rd_addr}, 32'd0);
    chk("arst_busy",   {31'b0, md_busy}, 32'd0);
    chk("arst_stall",  {31'b0, ex_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", {31'b0, md_busy}, 32'd0);

    // Unit recovers after reset
    issue_op(3'b000, 32'd3, 32'd5, 2'b00, 2'b00, 32'd0, 32'd0, 5'd22, 32'd15, MUL_LAT, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
